vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing on the pixel clock and supplies pixel coordinates and blanking to the sprite/palette render stages downstream. It also double-buffers a sprite origin written by the control side, so position updates land only at the start of vertical blanking and never tear mid-frame. It sits directly upstream of every DrawX/DrawY consumer.

## Interface
Parameters:
- H_VIS, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths
- V_VIS, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths

Ports:
- vga_clk  in  1  pixel clock (25 MHz nominal)
- Reset  in  1  asynchronous, active-high reset
- DrawX  out  10  current horizontal counter, range 0..799
- DrawY  out  10  current vertical counter, range 0..524
- hs  out  1  horizontal sync, active-low
- vs  out  1  vertical sync, active-low
- blank  out  1  1 = visible pixel (draw), 0 = blanked
- sync  out  1  composite sync, tied 0
- frame_start  out  1  one-cycle pulse on entry to vertical blanking
- pos_wr  in  1  write strobe for the sprite origin
- pos_x  in  10  new sprite X
- pos_y  in  10  new sprite Y
- pos_busy  out  1  a written origin is pending commit
- SpriteX  out  10  committed sprite X
- SpriteY  out  10  committed sprite Y

## Operation
- Horizontal counter hc runs 0..799 and wraps to 0. At wrap, vertical counter vc increments; vc runs 0..524 and wraps to 0. DrawX = hc, DrawY = vc.
- Decode, with the widths above:
  - hs = 0 for hc in 656..751.
  - vs = 0 for vc in 490..491.
  - blank = 1 iff hc < 640 and vc < 480.
- hs, vs and blank are registered. They are computed from next-state counters, so they align with DrawX/DrawY in the same cycle and are glitch-free.
- Commit point: the cycle where next-state is hc=0, vc=480. In that cycle frame_start is registered high for exactly 1 cycle.
- Origin handshake:
  - pos_wr latches pos_x/pos_y into a pending buffer and sets pos_busy.
  - A further pos_wr while pending overwrites the buffer; the latest write wins.
  - At the commit point the pending value loads into SpriteX/SpriteY and pos_busy clears.
  - If pos_wr coincides with the commit point, the incoming pos_x/pos_y is committed directly and pos_busy stays 0.
  - With no pending write, SpriteX/SpriteY hold their value.
- Reset (asynchronous, any time including mid-frame):
  - hc = vc = 0, DrawX = DrawY = 0.
  - hs = vs = 1, blank = 0, frame_start = 0.
  - pos_busy = 0, SpriteX = SpriteY = 0, pending buffer cleared.
  - Counting resumes on the first vga_clk edge after Reset falls. Pixel (0,0) of the first frame is therefore reported blank = 0.

## Timing
- Line = 800 clocks; frame = 800 × 525 = 420000 clocks.
- hs low for 96 clocks per line; vs low for 1600 clocks per frame.
- blank high for 640 consecutive clocks on each of lines 0..479.
- pos_wr to pos_busy = 1: one clock.
- Commit latency: up to one frame. SpriteX/SpriteY change on the same edge that raises frame_start.
- sync is constant 0.

## Configuration
- VGA_SYNC_ALIGN_EN defined:
  - blank is delayed 1 extra clock relative to DrawX/DrawY. This matches the synchronous sprite ROM read, so the render stage's output register samples the correct blank.
  - hs and vs are delayed 2 extra clocks, matching ROM plus output register latency at the DAC.
  - Delay registers reset to blank = 0, hs = vs = 1.
- VGA_SYNC_ALIGN_EN undefined: hs, vs and blank align with DrawX/DrawY as in Operation. No delay registers are instantiated.

## Test plan
- Reset release, run 420000 clocks → exactly 1 frame_start pulse, at DrawX=0, DrawY=480; counters return to (0,0) on clock 420000.
- Single line from DrawY=10:
  - hs falls at DrawX=656 and rises at DrawX=752.
  - blank is 1 for DrawX 0..639 and 0 from 640.
  - Macro on: blank edges occur 1 clock later, hs edges 2 clocks later.
- Vertical sync → vs = 0 for lines 490 and 491 only; total low time 1600 clocks.
- Origin handshake:
  - pos_wr with (100,200) at DrawY=100 → pos_busy = 1 next clock.
  - Second pos_wr with (300,50) at DrawY=200.
  - At the commit point: SpriteX=300, SpriteY=50, pos_busy = 0.
- pos_wr with (7,9) in the exact commit cycle → SpriteX=7, SpriteY=9 on that edge; pos_busy never rises.
- Reset asserted asynchronously at DrawX=400, DrawY=300 with a write pending → outputs take reset values immediately, pending write discarded, SpriteX = SpriteY = 0.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Bundle between the VGA timing generator and its consumers.
//               Carries raster coordinates, sync/blank decode, the frame
//               start pulse and the sprite-origin write handshake.
//   master : timing generator side (drives raster and sprite outputs,
//            receives pos_wr/pos_x/pos_y)
//   slave  : consumer / control side (the reverse)
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;
  logic [9:0] DrawX;        // horizontal counter 0..H_TOTAL-1
  logic [9:0] DrawY;        // vertical counter 0..V_TOTAL-1
  logic       hs;           // horizontal sync, active-low
  logic       vs;           // vertical sync, active-low
  logic       blank;        // 1 = visible pixel
  logic       sync;         // composite sync, constant 0
  logic       frame_start;  // one-cycle pulse on entry to vertical blanking
  logic       pos_wr;       // sprite origin write strobe
  logic [9:0] pos_x;        // new sprite X
  logic [9:0] pos_y;        // new sprite Y
  logic       pos_busy;     // written origin waiting for commit
  logic [9:0] SpriteX;      // committed sprite X
  logic [9:0] SpriteY;      // committed sprite Y

  modport master (
    output DrawX, DrawY, hs, vs, blank, sync, frame_start,
    output pos_busy, SpriteX, SpriteY,
    input  pos_wr, pos_x, pos_y
  );

  modport slave (
    input  DrawX, DrawY, hs, vs, blank, sync, frame_start,
    input  pos_busy, SpriteX, SpriteY,
    output pos_wr, pos_x, pos_y
  );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : 640x480@60 Hz VGA raster timing generator with a
//               double-buffered sprite origin that commits only at the start
//               of vertical blanking.
// Ports       : vga_clk - pixel clock
//               Reset   - asynchronous active-high reset
//               bus     - vga_timing_gen_if.master (raster outputs, sync and
//                         blank decode, frame_start, sprite origin handshake)
// Options     : VGA_SYNC_ALIGN_EN - when defined, blank is delayed one extra
//               clock and hs/vs two extra clocks to match the downstream
//               sprite ROM read and DAC output register.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33
) (
  input  logic             vga_clk,
  input  logic             Reset,
  vga_timing_gen_if.master bus
);

  localparam int unsigned c_H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned c_V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [9:0]  c_H_LAST   = 10'(c_H_TOTAL - 1);
  localparam logic [9:0]  c_V_LAST   = 10'(c_V_TOTAL - 1);
  localparam logic [9:0]  c_H_VIS    = 10'(H_VIS);
  localparam logic [9:0]  c_V_VIS    = 10'(V_VIS);
  localparam logic [9:0]  c_HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0]  c_HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0]  c_VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0]  c_VS_END   = 10'(V_VIS + V_FP + V_SYNC);

  logic [9:0] hc_q, vc_q;
  logic [9:0] hc_d, vc_d;
  logic       hs_d, vs_d, blank_d, commit_d;
  logic       hs_q, vs_q, blank_q, frame_start_q;
  logic       pend_q;
  logic [9:0] pend_x_q, pend_y_q;
  logic [9:0] sprite_x_q, sprite_y_q;

  // Next-state counters; all decodes use these so the registered sync and
  // blank line up with the registered counters on the same edge.
  always_comb begin
    hc_d = hc_q + 10'd1;
    vc_d = vc_q;
    if (hc_q == c_H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == c_V_LAST) ? '0 : vc_q + 10'd1;
    end
    hs_d     = !((hc_d >= c_HS_BEG) && (hc_d < c_HS_END));
    vs_d     = !((vc_d >= c_VS_BEG) && (vc_d < c_VS_END));
    blank_d  = (hc_d < c_H_VIS) && (vc_d < c_V_VIS);
    // Entry to vertical blanking: the origin commit point.
    commit_d = (hc_d == '0) && (vc_d == c_V_VIS);
  end

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      hc_q          <= '0;
      vc_q          <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      frame_start_q <= commit_d;
    end
  end

  // Sprite origin double buffer. A write landing on the commit edge bypasses
  // the pending buffer so pos_busy never rises for it.
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      pend_q     <= 1'b0;
      pend_x_q   <= '0;
      pend_y_q   <= '0;
      sprite_x_q <= '0;
      sprite_y_q <= '0;
    end else if (commit_d) begin
      pend_q <= 1'b0;
      if (bus.pos_wr) begin
        sprite_x_q <= bus.pos_x;
        sprite_y_q <= bus.pos_y;
      end else if (pend_q) begin
        sprite_x_q <= pend_x_q;
        sprite_y_q <= pend_y_q;
      end
    end else if (bus.pos_wr) begin
      pend_q   <= 1'b1;
      pend_x_q <= bus.pos_x;
      pend_y_q <= bus.pos_y;
    end
  end

`ifdef VGA_SYNC_ALIGN_EN
  // blank trails the coordinates by the ROM read; hs/vs additionally by the
  // render output register, so they reach the DAC with the pixel data.
  logic       blank_dly_q;
  logic [1:0] hs_dly_q, vs_dly_q;

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      blank_dly_q <= 1'b0;
      hs_dly_q    <= 2'b11;
      vs_dly_q    <= 2'b11;
    end else begin
      blank_dly_q <= blank_q;
      hs_dly_q    <= {hs_dly_q[0], hs_q};
      vs_dly_q    <= {vs_dly_q[0], vs_q};
    end
  end

  assign bus.blank = blank_dly_q;
  assign bus.hs    = hs_dly_q[1];
  assign bus.vs    = vs_dly_q[1];
`else
  assign bus.blank = blank_q;
  assign bus.hs    = hs_q;
  assign bus.vs    = vs_q;
`endif

  assign bus.DrawX       = hc_q;
  assign bus.DrawY       = vc_q;
  assign bus.sync        = 1'b0;
  assign bus.frame_start = frame_start_q;
  assign bus.pos_busy    = pend_q;
  assign bus.SpriteX     = sprite_x_q;
  assign bus.SpriteY     = sprite_y_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen. Uses a reduced raster
//               (80 x 57 clocks) so whole frames fit in a short run. The
//               reference position is derived from the count of clock edges
//               since reset release; sync/blank come from range decodes of
//               that position and the sprite origin from a pending-write
//               model. Works with or without VGA_SYNC_ALIGN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;
  localparam int H_VIS = 64, H_FP = 4, H_SYNC = 8, H_BP = 4;
  localparam int V_VIS = 48, V_FP = 3, V_SYNC = 2, V_BP = 4;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;   // 80
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;   // 57
  localparam int FRAME = H_TOT * V_TOT;                  // 4560
`ifdef VGA_SYNC_ALIGN_EN
  localparam int BD = 1, SD = 2;
`else
  localparam int BD = 0, SD = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_if bus();

  vga_timing_gen #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .vga_clk(clk),
    .Reset  (rst),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: edges since reset release and the origin buffer.
  int         t = 0;
  bit         m_pend = 0;
  logic [9:0] m_px = '0, m_py = '0, m_sx = '0, m_sy = '0;

  function automatic int hc_of(input int tt); return (tt % FRAME) % H_TOT; endfunction
  function automatic int vc_of(input int tt); return (tt % FRAME) / H_TOT; endfunction

  function automatic bit blank_at(input int tt);
    if (tt <= 0) return 1'b0;
    return (hc_of(tt) < H_VIS) && (vc_of(tt) < V_VIS);
  endfunction
  function automatic bit hs_at(input int tt);
    if (tt <= 0) return 1'b1;
    return !(hc_of(tt) >= H_VIS + H_FP && hc_of(tt) < H_VIS + H_FP + H_SYNC);
  endfunction
  function automatic bit vs_at(input int tt);
    if (tt <= 0) return 1'b1;
    return !(vc_of(tt) >= V_VIS + V_FP && vc_of(tt) < V_VIS + V_FP + V_SYNC);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0d)", nm, act, exp, t);
    end
  endtask

  task automatic compare_all();
    check("DrawX", int'(bus.DrawX), hc_of(t));
    check("DrawY", int'(bus.DrawY), vc_of(t));
    check("hs", int'(bus.hs), int'(hs_at(t - SD)));
    check("vs", int'(bus.vs), int'(vs_at(t - SD)));
    check("blank", int'(bus.blank), int'(blank_at(t - BD)));
    check("sync", int'(bus.sync), 0);
    check("frame_start", int'(bus.frame_start),
          int'(t > 0 && hc_of(t) == 0 && vc_of(t) == V_VIS));
    check("pos_busy", int'(bus.pos_busy), int'(m_pend));
    check("SpriteX", int'(bus.SpriteX), int'(m_sx));
    check("SpriteY", int'(bus.SpriteY), int'(m_sy));
  endtask

  // One clock: drive inputs, update the model on the edge, compare after it.
  task automatic step(input bit wr, input logic [9:0] x, input logic [9:0] y);
    bus.pos_wr = wr;
    bus.pos_x  = x;
    bus.pos_y  = y;
    @(posedge clk);
    t++;
    if (hc_of(t) == 0 && vc_of(t) == V_VIS) begin
      if (wr) begin
        m_sx = x; m_sy = y;
      end else if (m_pend) begin
        m_sx = m_px; m_sy = m_py;
      end
      m_pend = 0;
    end else if (wr) begin
      m_px = x; m_py = y; m_pend = 1;
    end
    #1;
    bus.pos_wr = 1'b0;
    compare_all();
  endtask

  task automatic run_to(input int x, input int y);
    int n = 0;
    while (!(hc_of(t) == x && vc_of(t) == y)) begin
      if (n > FRAME + 4) begin
        check("run_to timeout", 0, 1);
        return;
      end
      step(1'b0, '0, '0);
      n++;
    end
  endtask

  initial begin
    int fs_cnt, fs_x, fs_y, fs_t, vs_low, blank_cnt;
    int hs_fall, hs_rise, blank_fall;
    bit prev_hs, prev_blank;

    bus.pos_wr = 1'b0;
    bus.pos_x  = '0;
    bus.pos_y  = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    check("reset hs literal", int'(bus.hs), 1);
    check("reset blank literal", int'(bus.blank), 0);
    rst = 1'b0;

    // One full frame from reset release.
    fs_cnt = 0; fs_x = -1; fs_y = -1; fs_t = -1; vs_low = 0; blank_cnt = 0;
    hs_fall = -1; hs_rise = -1; blank_fall = -1;
    prev_hs = 1'b1; prev_blank = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, '0, '0);
      if (bus.frame_start) begin
        fs_cnt++; fs_x = int'(bus.DrawX); fs_y = int'(bus.DrawY); fs_t = t;
      end
      if (!bus.vs) vs_low++;
      if (bus.DrawY == 10'd10) begin
        if (prev_hs && !bus.hs) hs_fall = int'(bus.DrawX);
        if (!prev_hs && bus.hs) hs_rise = int'(bus.DrawX);
        if (prev_blank && !bus.blank) blank_fall = int'(bus.DrawX);
        if (bus.blank) blank_cnt++;
      end
      prev_hs = bus.hs;
      prev_blank = bus.blank;
    end
    check("frame_start count", fs_cnt, 1);
    check("frame_start DrawX", fs_x, 0);
    check("frame_start DrawY", fs_y, 48);
    check("frame_start clock", fs_t, 3840);
    check("wrap DrawX", int'(bus.DrawX), 0);
    check("wrap DrawY", int'(bus.DrawY), 0);
    check("vs low clocks", vs_low, 160);
    check("hs fall DrawX", hs_fall, 68 + SD);
    check("hs rise DrawX", hs_rise, 76 + SD);
    check("blank fall DrawX", blank_fall, 64 + BD);
    check("blank high clocks line10", blank_cnt, 64);

    // Origin handshake: latest pending write wins at the commit point.
    run_to(0, 10);
    step(1'b1, 10'd100, 10'd200);
    check("busy after write", int'(bus.pos_busy), 1);
    run_to(0, 20);
    step(1'b1, 10'd300, 10'd50);
    run_to(0, 48);
    check("commit SpriteX", int'(bus.SpriteX), 300);
    check("commit SpriteY", int'(bus.SpriteY), 50);
    check("commit busy", int'(bus.pos_busy), 0);
    check("commit frame_start", int'(bus.frame_start), 1);

    // Write in the exact commit cycle goes straight through.
    run_to(H_TOT - 1, V_VIS - 1);
    step(1'b1, 10'd7, 10'd9);
    check("direct SpriteX", int'(bus.SpriteX), 7);
    check("direct SpriteY", int'(bus.SpriteY), 9);
    check("direct busy", int'(bus.pos_busy), 0);

    // Randomized writes across several commit points.
    for (int i = 0; i < 2 * FRAME; i++)
      step($urandom_range(0, 99) < 2, 10'($urandom), 10'($urandom));

    // Asynchronous reset mid-frame with a pending write.
    run_to(40, 30);
    step(1'b1, 10'd11, 10'd22);
    check("busy before reset", int'(bus.pos_busy), 1);
    #3;
    rst = 1'b1;
    #1;
    t = 0; m_pend = 0; m_px = '0; m_py = '0; m_sx = '0; m_sy = '0;
    compare_all();
    check("async DrawX", int'(bus.DrawX), 0);
    check("async DrawY", int'(bus.DrawY), 0);
    check("async busy", int'(bus.pos_busy), 0);
    check("async SpriteX", int'(bus.SpriteX), 0);
    check("async hs", int'(bus.hs), 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_to(0, 48);
    check("discarded SpriteX", int'(bus.SpriteX), 0);
    check("discarded SpriteY", int'(bus.SpriteY), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
